esi_window_acc: RTL and testbench

Parametrised successor to the team's single-channel integer accumulators. It accumulates a valid/ready stream of integers into fixed-size windows (or windows closed early by a marker). Each window total is emitted on a valid/ready output channel, together with the beat count and an overflow flag. It sits between an ESI integer producer and a downstream consumer that needs per-window sums, with full backpressure on both sides.

---
 rtl/esi_window_acc.sv | 127 ++++++++++++
 tb/tb_esi_window_acc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esi_window_acc.sv
// Window accumulator: sums a valid/ready integer stream into windows of WINDOW
// beats (or shorter, closed by in_last) and emits each total with count and overflow.
module esi_window_acc #(
  parameter int IN_W     = 32,
  parameter int ACC_W    = 32,
  parameter int WINDOW   = 8,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  parameter int CNT_W    = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  if (ACC_W < IN_W) begin : g_bad_acc_w
    $error("esi_window_acc: ACC_W must be >= IN_W");
  end
  if (WINDOW < 1) begin : g_bad_window
    $error("esi_window_acc: WINDOW must be >= 1");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   opnd;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   sum;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hs;
  logic             close;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready,
  // a result transfers where out_valid && out_ready. in_ready depends only on
  // rstn and the state register, never on out_ready.
  assign in_ready = rstn && (state == ACCUM);
  assign hs       = in_valid && in_ready;
  assign cnt_inc  = cnt + 1'b1;
  assign close    = (cnt_inc == WIN_C) || in_last;

  always_comb begin
    opnd    = '0;
    acc_x   = '0;
    ovf_now = 1'b0;
    if (SIGNED != 0) begin
      opnd  = {{(ACC_W + 1 - IN_W){in_data[IN_W-1]}}, in_data};
      acc_x = {acc[ACC_W-1], acc};
    end else begin
      opnd  = {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
      acc_x = {1'b0, acc};
    end
    sum = acc_x + opnd;
    if (SIGNED != 0)
      ovf_now = (acc_x[ACC_W-1] == opnd[ACC_W-1]) && (sum[ACC_W-1] != acc_x[ACC_W-1]);
    else
      ovf_now = sum[ACC_W];
    acc_nxt = sum[ACC_W-1:0];
    // Signed overflow can only go negative when both operands are negative.
    if (ovf_now && (SATURATE != 0)) begin
      if (SIGNED != 0)
        acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (hs) begin
            if (close) begin
              out_data     <= acc_nxt;
              out_count    <= cnt_inc;
              out_overflow <= ovf || ovf_now;
              acc          <= '0;
              cnt          <= '0;
              ovf          <= 1'b0;
              out_valid    <= 1'b1;
              state        <= EMIT;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_inc;
              ovf <= ovf || ovf_now;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_esi_window_acc.sv
// Directed bench for esi_window_acc: several parameterisations share one stimulus
// bus; each step checks the instance it targets against hand-computed values.
module tb_esi_window_acc;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        w8_rdy, w8_ov, w8_of;
  logic [31:0] w8_od;
  logic [3:0]  w8_oc;
  logic        w4_rdy, w4_ov, w4_of;
  logic [31:0] w4_od;
  logic [2:0]  w4_oc;
  logic        w1_rdy, w1_ov, w1_of;
  logic [31:0] w1_od;
  logic [0:0]  w1_oc;
  logic        wr_rdy, wr_ov, wr_of;
  logic [7:0]  wr_od;
  logic [1:0]  wr_oc;
  logic        sa_rdy, sa_ov, sa_of;
  logic [7:0]  sa_od;
  logic [1:0]  sa_oc;
  logic        ss_rdy, ss_ov, ss_of;
  logic [7:0]  ss_od;
  logic [1:0]  ss_oc;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  cnt_q[$];
  logic        ovf_q[$];

  esi_window_acc u_w8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(w8_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(w8_ov), .out_ready(out_ready), .out_data(w8_od),
    .out_count(w8_oc), .out_overflow(w8_of));

  esi_window_acc #(.WINDOW(4)) u_w4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(w4_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(w4_ov), .out_ready(out_ready), .out_data(w4_od),
    .out_count(w4_oc), .out_overflow(w4_of));

  esi_window_acc #(.WINDOW(1)) u_w1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(w1_rdy), .in_data(in_data),
    .in_last(in_last), .out_valid(w1_ov), .out_ready(out_ready), .out_data(w1_od),
    .out_count(w1_oc), .out_overflow(w1_of));

  esi_window_acc #(.IN_W(8), .ACC_W(8), .WINDOW(2)) u_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(wr_rdy), .in_data(in_data[7:0]),
    .in_last(in_last), .out_valid(wr_ov), .out_ready(out_ready), .out_data(wr_od),
    .out_count(wr_oc), .out_overflow(wr_of));

  esi_window_acc #(.IN_W(8), .ACC_W(8), .WINDOW(2), .SATURATE(1)) u_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(sa_rdy), .in_data(in_data[7:0]),
    .in_last(in_last), .out_valid(sa_ov), .out_ready(out_ready), .out_data(sa_od),
    .out_count(sa_oc), .out_overflow(sa_of));

  esi_window_acc #(.IN_W(8), .ACC_W(8), .WINDOW(2), .SIGNED(1), .SATURATE(1)) u_ssat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ss_rdy), .in_data(in_data[7:0]),
    .in_last(in_last), .out_valid(ss_ov), .out_ready(out_ready), .out_data(ss_od),
    .out_count(ss_oc), .out_overflow(ss_of));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic rnd_pop();
    if (exp_q.size() == 0) begin
      chk("rnd_spurious_valid", 64'(w8_ov), 64'(0));
    end else begin
      chk("rnd_data", 64'(w8_od), 64'(exp_q.pop_front()));
      chk("rnd_count", 64'(w8_oc), 64'(cnt_q.pop_front()));
      chk("rnd_ovf", 64'(w8_of), 64'(ovf_q.pop_front()));
    end
  endtask

  initial begin
    logic [32:0] s;
    logic [31:0] acc_m;
    logic [3:0]  cnt_m;
    logic        ovf_m;
    logic        v, l, r;
    logic [31:0] d;
    int          beats;
    int          cyc;

    rstn = 1'b0;
    drive(0, 0, 0, 1);
    tick();
    tick();
    // Reset state
    chk("rst_out_valid", 64'(w8_ov), 0);
    chk("rst_out_data", 64'(w8_od), 0);
    chk("rst_out_count", 64'(w8_oc), 0);
    chk("rst_out_overflow", 64'(w8_of), 0);
    chk("rst_in_ready_low", 64'(w8_rdy), 0);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready_high", 64'(w8_rdy), 1);

    // Full window of 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 0, 1);
      chk("t1_in_ready", 64'(w8_rdy), 1);
      tick();
    end
    chk("t1_out_valid", 64'(w8_ov), 1);
    chk("t1_out_data", 64'(w8_od), 36);
    chk("t1_out_count", 64'(w8_oc), 8);
    chk("t1_out_overflow", 64'(w8_of), 0);
    chk("t1_in_ready_emit", 64'(w8_rdy), 0);
    drive(0, 0, 0, 1);
    tick();
    chk("t1_in_ready_back", 64'(w8_rdy), 1);
    chk("t1_out_valid_drop", 64'(w8_ov), 0);
    chk("t1_out_data_held", 64'(w8_od), 36);

    // Early close by in_last, then a full window with in_last on the last beat
    do_reset();
    drive(1, 5, 0, 1);
    tick();
    drive(1, 6, 1, 1);
    tick();
    chk("t2_out_valid", 64'(w4_ov), 1);
    chk("t2_out_data", 64'(w4_od), 11);
    chk("t2_out_count", 64'(w4_oc), 2);
    drive(1, 1, 0, 1);
    tick();
    chk("t2_back_accum", 64'(w4_rdy), 1);
    chk("t2_out_data_held", 64'(w4_od), 11);
    tick();
    tick();
    tick();
    drive(1, 1, 1, 1);
    tick();
    chk("t2b_out_valid", 64'(w4_ov), 1);
    chk("t2b_out_data", 64'(w4_od), 4);
    chk("t2b_out_count", 64'(w4_oc), 4);
    drive(0, 0, 0, 1);
    tick();
    chk("t2b_no_empty_1", 64'(w4_ov), 0);
    tick();
    chk("t2b_no_empty_2", 64'(w4_ov), 0);

    // Unsigned wrap/saturate and WINDOW=1
    do_reset();
    drive(1, 200, 0, 1);
    tick();
    chk("w1_out_valid", 64'(w1_ov), 1);
    chk("w1_out_data", 64'(w1_od), 200);
    chk("w1_out_count", 64'(w1_oc), 1);
    drive(1, 100, 0, 1);
    tick();
    chk("t3_wrap_valid", 64'(wr_ov), 1);
    chk("t3_wrap_data", 64'(wr_od), 44);
    chk("t3_wrap_ovf", 64'(wr_of), 1);
    chk("t3_wrap_count", 64'(wr_oc), 2);
    chk("t3_sat_data", 64'(sa_od), 255);
    chk("t3_sat_ovf", 64'(sa_of), 1);
    chk("t3_ssat_data", 64'(ss_od), 44);
    chk("t3_ssat_ovf", 64'(ss_of), 0);

    // Signed saturation: -100 + -100 clamps to -128; then 100 + -50 = 50
    do_reset();
    drive(1, 32'h9c, 0, 1);
    tick();
    tick();
    chk("t4_ssat_data", 64'(ss_od), 64'h80);
    chk("t4_ssat_ovf", 64'(ss_of), 1);
    chk("t4_wrap_data", 64'(wr_od), 64'h38);
    tick();
    drive(1, 100, 0, 1);
    tick();
    drive(1, 32'hce, 0, 1);
    tick();
    chk("t4b_ssat_valid", 64'(ss_ov), 1);
    chk("t4b_ssat_data", 64'(ss_od), 64'h32);
    chk("t4b_ssat_ovf", 64'(ss_of), 0);
    chk("t4b_wrap_data", 64'(wr_od), 64'h32);
    chk("t4b_wrap_ovf", 64'(wr_of), 1);

    // Backpressure on a WINDOW=4 result
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i), 0, 0);
      tick();
    end
    drive(1, 99, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("t5_in_ready", 64'(w4_rdy), 0);
      chk("t5_out_valid", 64'(w4_ov), 1);
      chk("t5_out_data", 64'(w4_od), 10);
      chk("t5_out_count", 64'(w4_oc), 4);
      chk("t5_out_overflow", 64'(w4_of), 0);
      if (k < 5) tick();
    end
    drive(1, 7, 1, 1);
    tick();
    chk("t5_release_valid", 64'(w4_ov), 0);
    chk("t5_release_ready", 64'(w4_rdy), 1);
    tick();
    chk("t5_next_valid", 64'(w4_ov), 1);
    chk("t5_next_data", 64'(w4_od), 7);
    chk("t5_next_count", 64'(w4_oc), 1);

    // Reset mid-window and mid-EMIT
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 0, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    drive(1, 10, 0, 1);
    tick();
    drive(1, 20, 0, 1);
    tick();
    drive(1, 30, 0, 1);
    tick();
    rstn = 1'b0;
    drive(0, 0, 0, 1);
    tick();
    rstn = 1'b1;
    chk("t6_rst_valid", 64'(w8_ov), 0);
    chk("t6_rst_data", 64'(w8_od), 0);
    chk("t6_rst_count", 64'(w8_oc), 0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 0, 0);
      tick();
    end
    chk("t6_sum_after_rst", 64'(w8_od), 36);
    chk("t6_count_after_rst", 64'(w8_oc), 8);
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    rstn = 1'b1;
    chk("t6_emit_rst_valid", 64'(w8_ov), 0);
    chk("t6_emit_rst_data", 64'(w8_od), 0);

    // Random valid/ready/last against a reference model of the default instance
    do_reset();
    acc_m = '0;
    cnt_m = '0;
    ovf_m = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 2000 && cyc < 20000) begin
      v = 1'($urandom_range(0, 1));
      d = $urandom;
      l = ($urandom_range(0, 9) == 0);
      r = 1'($urandom_range(0, 1));
      drive(v, d, l, r);
      if (w8_ov && r) rnd_pop();
      if (v && w8_rdy) begin
        s     = {1'b0, acc_m} + {1'b0, d};
        acc_m = s[31:0];
        ovf_m = ovf_m | s[32];
        cnt_m = cnt_m + 4'd1;
        beats++;
        if (cnt_m == 4'd8 || l) begin
          exp_q.push_back(acc_m);
          cnt_q.push_back(cnt_m);
          ovf_q.push_back(ovf_m);
          acc_m = '0;
          cnt_m = '0;
          ovf_m = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    chk("rnd_beat_budget", 64'(beats >= 2000), 1);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      if (w8_ov) rnd_pop();
      tick();
    end
    chk("rnd_queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
